// File: rtl/fft_8p_frame_seq.sv
// Frame sequencer for an 8-point radix-2 FFT: loads eight samples from a ROM,
// then steps the three butterfly stages and holds the result until accepted.
module fft_8p_frame_seq #(
    parameter int ADDR_W       = 8,
    parameter int BF1_SERIAL   = 0,
    parameter int AUTO_RESTART = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              out_ready,
    output logic              s2p_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              en_bf1_1,
    output logic              en_bf1_2,
    output logic              en_bf1_3,
    output logic              en_bf1_4,
    output logic              en_bf2_1,
    output logic              en_bf2_2,
    output logic              en_bf3,
    output logic              busy,
    output logic              out_valid,
    output logic [7:0]        frame_cnt,
    output logic [2:0]        state_dbg
);

    // Handshake: the frame in X_0..X_7 is transferred on any rising edge where
    // out_valid=1 and out_ready=1; out_valid then drops (or the next load begins).
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_BF1  = 3'd2,
        S_BF2  = 3'd3,
        S_BF3  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [2:0] BF1_LAST = (BF1_SERIAL != 0) ? 3'd3 : 3'd0;

    state_t            state, state_n;
    logic [2:0]        cnt, cnt_n;
    logic [ADDR_W-1:0] base, base_n;
    logic [7:0]        frame_cnt_n;

    logic              s2p_d, bf3_d, busy_d, valid_d;
    logic [ADDR_W-1:0] addr_d;
    logic [3:0]        bf1_d, bf1_q;
    logic [1:0]        bf2_d, bf2_q;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        base_n      = base;
        frame_cnt_n = frame_cnt;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_n = S_LOAD;
                    cnt_n   = 3'd0;
                end
            end
            S_LOAD: begin
                if (cnt == 3'd7) begin
                    state_n = S_BF1;
                    cnt_n   = 3'd0;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            S_BF1: begin
                if (cnt == BF1_LAST) begin
                    state_n = S_BF2;
                    cnt_n   = 3'd0;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            S_BF2: state_n = S_BF3;
            S_BF3: state_n = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    frame_cnt_n = frame_cnt + 8'd1;
                    base_n      = base + ADDR_W'(8);
                    cnt_n       = 3'd0;
                    state_n     = (AUTO_RESTART != 0) ? S_LOAD : S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Abort overrides everything, including a same-cycle acceptance.
        if (abort && state != S_IDLE) begin
            state_n     = S_IDLE;
            cnt_n       = 3'd0;
            base_n      = base;
            frame_cnt_n = frame_cnt;
        end
    end

    // Outputs are decoded from the next state so they land in flops aligned with it.
    always_comb begin
        s2p_d   = 1'b0;
        addr_d  = '0;
        bf1_d   = 4'b0000;
        bf2_d   = 2'b00;
        bf3_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = (state_n != S_IDLE);
        case (state_n)
            S_LOAD: begin
                s2p_d  = 1'b1;
                addr_d = base_n + ADDR_W'(cnt_n);
            end
            S_BF1:  bf1_d   = (BF1_SERIAL != 0) ? (4'b0001 << cnt_n[1:0]) : 4'b1111;
            S_BF2:  bf2_d   = 2'b11;
            S_BF3:  bf3_d   = 1'b1;
            S_DONE: valid_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 3'd0;
            base      <= '0;
            frame_cnt <= 8'd0;
            s2p_en    <= 1'b0;
            rom_addr  <= '0;
            bf1_q     <= 4'b0000;
            bf2_q     <= 2'b00;
            en_bf3    <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            base      <= base_n;
            frame_cnt <= frame_cnt_n;
            s2p_en    <= s2p_d;
            rom_addr  <= addr_d;
            bf1_q     <= bf1_d;
            bf2_q     <= bf2_d;
            en_bf3    <= bf3_d;
            busy      <= busy_d;
            out_valid <= valid_d;
        end
    end

    assign en_bf1_1  = bf1_q[0];
    assign en_bf1_2  = bf1_q[1];
    assign en_bf1_3  = bf1_q[2];
    assign en_bf1_4  = bf1_q[3];
    assign en_bf2_1  = bf2_q[0];
    assign en_bf2_2  = bf2_q[1];
    assign state_dbg = state;

endmodule

// File: tb/tb_fft_8p_frame_seq.sv
// Bench for fft_8p_frame_seq: three parameter variants driven by shared stimulus,
// each checked every cycle against a frame-timeline model.
module tb_fft_8p_frame_seq;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic out_ready = 1'b0;
    bit   chk_en = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wire       d_s2p   [3];
    wire [7:0] d_addr  [3];
    wire [3:0] d_bf1   [3];
    wire [1:0] d_bf2   [3];
    wire       d_bf3   [3];
    wire       d_busy  [3];
    wire       d_ov    [3];
    wire [7:0] d_fc    [3];
    wire [2:0] d_state [3];

    assign d_addr[2][7:4] = 4'h0;

    fft_8p_frame_seq #(.ADDR_W(8), .BF1_SERIAL(0), .AUTO_RESTART(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .out_ready(out_ready),
        .s2p_en(d_s2p[0]), .rom_addr(d_addr[0]),
        .en_bf1_1(d_bf1[0][0]), .en_bf1_2(d_bf1[0][1]), .en_bf1_3(d_bf1[0][2]), .en_bf1_4(d_bf1[0][3]),
        .en_bf2_1(d_bf2[0][0]), .en_bf2_2(d_bf2[0][1]), .en_bf3(d_bf3[0]),
        .busy(d_busy[0]), .out_valid(d_ov[0]), .frame_cnt(d_fc[0]), .state_dbg(d_state[0]));

    fft_8p_frame_seq #(.ADDR_W(8), .BF1_SERIAL(1), .AUTO_RESTART(0)) dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .out_ready(out_ready),
        .s2p_en(d_s2p[1]), .rom_addr(d_addr[1]),
        .en_bf1_1(d_bf1[1][0]), .en_bf1_2(d_bf1[1][1]), .en_bf1_3(d_bf1[1][2]), .en_bf1_4(d_bf1[1][3]),
        .en_bf2_1(d_bf2[1][0]), .en_bf2_2(d_bf2[1][1]), .en_bf3(d_bf3[1]),
        .busy(d_busy[1]), .out_valid(d_ov[1]), .frame_cnt(d_fc[1]), .state_dbg(d_state[1]));

    fft_8p_frame_seq #(.ADDR_W(4), .BF1_SERIAL(0), .AUTO_RESTART(1)) dut2 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .out_ready(out_ready),
        .s2p_en(d_s2p[2]), .rom_addr(d_addr[2][3:0]),
        .en_bf1_1(d_bf1[2][0]), .en_bf1_2(d_bf1[2][1]), .en_bf1_3(d_bf1[2][2]), .en_bf1_4(d_bf1[2][3]),
        .en_bf2_1(d_bf2[2][0]), .en_bf2_2(d_bf2[2][1]), .en_bf3(d_bf3[2]),
        .busy(d_busy[2]), .out_valid(d_ov[2]), .frame_cnt(d_fc[2]), .state_dbg(d_state[2]));

    // Model: a frame is a timeline t=0.. counted from the first load cycle.
    int serial  [3] = '{0, 1, 0};
    int auto_rs [3] = '{0, 0, 1};
    int mask    [3] = '{255, 255, 15};
    bit m_active [3] = '{0, 0, 0};
    int m_t      [3] = '{0, 0, 0};
    int m_base   [3] = '{0, 0, 0};
    int m_fcnt   [3] = '{0, 0, 0};

    function automatic int done_t(int i);
        return (serial[i] != 0) ? 14 : 11;
    endfunction

    function automatic logic [25:0] pack(logic s2p, logic [7:0] addr, logic [3:0] bf1,
                                         logic [1:0] bf2, logic bf3, logic bsy, logic ov,
                                         logic [7:0] fc);
        return {s2p, (s2p ? addr : 8'h00), bf1, bf2, bf3, bsy, ov, fc};
    endfunction

    function automatic logic [25:0] model_vec(int i);
        int         l1 = (serial[i] != 0) ? 4 : 1;
        int         t = m_t[i];
        logic       s2p = 1'b0, bf3 = 1'b0, ov = 1'b0;
        logic [7:0] addr = 8'h00;
        logic [3:0] bf1 = 4'h0;
        logic [1:0] bf2 = 2'b00;
        if (m_active[i]) begin
            if (t < 8) begin
                s2p  = 1'b1;
                addr = 8'((m_base[i] + t) & mask[i]);
            end else if (t < 8 + l1) begin
                bf1 = (serial[i] != 0) ? 4'(1 << (t - 8)) : 4'hf;
            end else if (t == 8 + l1) begin
                bf2 = 2'b11;
            end else if (t == 9 + l1) begin
                bf3 = 1'b1;
            end else begin
                ov = 1'b1;
            end
        end
        return pack(s2p, addr, bf1, bf2, bf3, m_active[i], ov, 8'(m_fcnt[i]));
    endfunction

    function automatic logic [25:0] dut_vec(int i);
        return pack(d_s2p[i], d_addr[i], d_bf1[i], d_bf2[i], d_bf3[i], d_busy[i], d_ov[i], d_fc[i]);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_active[i] <= 1'b0;
                m_t[i]      <= 0;
                m_base[i]   <= 0;
                m_fcnt[i]   <= 0;
            end else if (!m_active[i]) begin
                if (start && !abort) begin
                    m_active[i] <= 1'b1;
                    m_t[i]      <= 0;
                end
            end else if (abort) begin
                m_active[i] <= 1'b0;
            end else if (m_t[i] >= done_t(i)) begin
                if (out_ready) begin
                    m_fcnt[i] <= (m_fcnt[i] + 1) % 256;
                    m_base[i] <= (m_base[i] + 8) & mask[i];
                    m_t[i]    <= 0;
                    if (auto_rs[i] == 0) m_active[i] <= 1'b0;
                end
            end else begin
                m_t[i] <= m_t[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) check($sformatf("dut%0d_cycle", i), 32'(dut_vec(i)), 32'(model_vec(i)));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int f_s2p0, f_bf1_0, f_bf1_1, f_bf2_1, f_ov0, f_ov1;
        logic [7:0] addr_c1;
        f_s2p0 = -1; f_bf1_0 = -1; f_bf1_1 = -1; f_bf2_1 = -1; f_ov0 = -1; f_ov1 = -1;
        addr_c1 = 8'hff;

        repeat (2) tick();
        chk_en = 1'b1;
        check("rst_busy", 32'(d_busy[0]), 32'd0);
        check("rst_addr", 32'(d_addr[0]), 32'd0);
        reset = 1'b0;

        // Nominal frame with immediate acceptance.
        start = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            start = 1'b0;
            if (c == 1) addr_c1 = d_addr[0];
            if (f_s2p0 < 0 && d_s2p[0]) f_s2p0 = c;
            if (f_bf1_0 < 0 && d_bf1[0] == 4'hf) f_bf1_0 = c;
            if (f_bf1_1 < 0 && d_bf1[1] == 4'h1) f_bf1_1 = c;
            if (f_bf2_1 < 0 && d_bf2[1] == 2'b11) f_bf2_1 = c;
            if (f_ov0 < 0 && d_ov[0]) f_ov0 = c;
            if (f_ov1 < 0 && d_ov[1]) f_ov1 = c;
        end
        check("nom_first_s2p", 32'(f_s2p0), 32'd1);
        check("nom_addr_c1", 32'(addr_c1), 32'd0);
        check("nom_bf1_cycle", 32'(f_bf1_0), 32'd9);
        check("nom_ov_cycle", 32'(f_ov0), 32'd12);
        check("ser_bf1_cycle", 32'(f_bf1_1), 32'd9);
        check("ser_bf2_cycle", 32'(f_bf2_1), 32'd13);
        check("ser_ov_cycle", 32'(f_ov1), 32'd15);
        check("nom_frame_cnt", 32'(d_fc[0]), 32'd1);
        abort = 1'b1; out_ready = 1'b0;
        tick();
        abort = 1'b0;

        // Backpressure in DONE, then a second frame.
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            start = 1'b0;
        end
        check("bp_valid_held", 32'(d_ov[0]), 32'd1);
        check("bp_no_enables", 32'({d_s2p[0], d_bf1[0], d_bf2[0], d_bf3[0]}), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_frame_cnt", 32'(d_fc[0]), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("f2_addr", 32'(d_addr[0]), 32'd16);

        // Abort at load cycle k=4, then reread the same addresses.
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(d_busy[0]), 32'd0);
        check("abort_fcnt", 32'(d_fc[0]), 32'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("reread_addr", 32'(d_addr[0]), 32'd16);
        repeat (11) tick();
        check("done_valid", 32'(d_ov[0]), 32'd1);
        abort = 1'b1; out_ready = 1'b1;
        tick();
        abort = 1'b0; out_ready = 1'b0;
        check("abort_done_fcnt", 32'(d_fc[0]), 32'd2);
        check("abort_done_ov", 32'(d_ov[0]), 32'd0);

        // Reset in the middle of BF2.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("pre_rst_bf2", 32'(d_bf2[0]), 32'd3);
        #2 reset = 1'b1;
        #1 check("rst_async_all", 32'(dut_vec(0)), 32'd0);
        check("rst_async_ser", 32'(dut_vec(1)), 32'd0);
        repeat (2) tick();
        reset = 1'b0; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 32'(d_busy[0]), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_after_rst", 32'(d_busy[0]), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Auto restart and address wrap on the 4-bit variant.
        out_ready = 1'b1; start = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            start = 1'b0;
            if (c == 12) check("ar_valid_c12", 32'(d_ov[2]), 32'd1);
            if (c == 13) begin
                check("ar_reload_s2p", 32'(d_s2p[2]), 32'd1);
                check("ar_reload_addr", 32'(d_addr[2]), 32'd8);
                check("ar_dut0_idle", 32'(d_busy[0]), 32'd0);
            end
            if (c == 25) begin
                check("ar_wrap_addr", 32'(d_addr[2]), 32'd0);
                check("ar_wrap_fcnt", 32'(d_fc[2]), 32'd2);
            end
        end
        abort = 1'b1; out_ready = 1'b0;
        tick();
        abort = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            tick();
            start     = ($urandom_range(0, 3) == 0);
            abort     = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                tick();
                #2 reset = 1'b0;
            end
        end
        start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
